// File: rtl/mandelbrot_pixel_engine.sv
// Mandelbrot pixel engine: scans the frame in raster order, maps each pixel to a
// complex point c, runs the escape-time iteration z = z^2 + c in signed fixed
// point (one step per clock) and writes the iteration count of each pixel to the
// frame buffer over a valid/ready write port.
module mandelbrot_pixel_engine #(
    parameter int                   H_ACTIVE  = 64,
    parameter int                   V_ACTIVE  = 48,
    parameter int                   BIT_WIDTH = 32,
    parameter int                   FRAC      = 28,
    parameter int                   MAX_ITER  = 255,
    parameter int                   ITER_W    = 8,
    parameter int                   ADDR_W    = 12,
    parameter logic [BIT_WIDTH-1:0] RE_MIN    = 32'hE0000000,
    parameter logic [BIT_WIDTH-1:0] RE_STEP   = 32'h00C00000,
    parameter logic [BIT_WIDTH-1:0] IM_MAX    = 32'h12000000,
    parameter logic [BIT_WIDTH-1:0] IM_STEP   = 32'h00C00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ITER_W-1:0] wr_data
);

    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE + 1) : 1;
    localparam int PW  = 2 * BIT_WIDTH;

    // 4.0 expressed at the scale of a full-precision product (2*FRAC fraction bits)
    localparam logic [PW:0] ESC_LIMIT = {{PW{1'b0}}, 1'b1} << (2 * FRAC + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ITER  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [X_W-1:0]      x_q,        x_d;
    logic [Y_W-1:0]      y_q,        y_d;
    logic [BIT_WIDTH-1:0] cr_q,      cr_d;
    logic [BIT_WIDTH-1:0] ci_q,      ci_d;
    logic [BIT_WIDTH-1:0] zr_q,      zr_d;
    logic [BIT_WIDTH-1:0] zi_q,      zi_d;
    logic [ITER_W-1:0]   iter_q,     iter_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [ITER_W-1:0]   wr_data_q,  wr_data_d;

    // Datapath intermediates
    logic signed [PW-1:0] zr_ext_s;
    logic signed [PW-1:0] zi_ext_s;
    logic signed [PW-1:0] prod_rr_s;
    logic signed [PW-1:0] prod_ii_s;
    logic signed [PW-1:0] prod_ri_s;
    logic signed [PW-1:0] diff_s;
    logic [PW:0]          mag_s;
    logic                 escaped_s;
    logic                 iter_max_s;
    logic [BIT_WIDTH-1:0] zr_next_s;
    logic [BIT_WIDTH-1:0] zi_next_s;
    logic                 last_x_s;
    logic                 last_pix_s;
    logic                 unused_bits_s;

    // Full-precision products, escape test and the next z value
    always_comb begin
        zr_ext_s   = {{BIT_WIDTH{zr_q[BIT_WIDTH-1]}}, zr_q};
        zi_ext_s   = {{BIT_WIDTH{zi_q[BIT_WIDTH-1]}}, zi_q};
        prod_rr_s  = zr_ext_s * zr_ext_s;
        prod_ii_s  = zi_ext_s * zi_ext_s;
        prod_ri_s  = zr_ext_s * zi_ext_s;
        // squares are never negative, so the extra bit only absorbs the carry
        mag_s      = {prod_rr_s[PW-1], prod_rr_s} + {prod_ii_s[PW-1], prod_ii_s};
        escaped_s  = (mag_s > ESC_LIMIT);
        iter_max_s = (iter_q == ITER_W'(MAX_ITER));
        diff_s     = prod_rr_s - prod_ii_s;
        // a slice starting at FRAC is the arithmetic shift truncated to BIT_WIDTH
        zr_next_s  = diff_s[FRAC +: BIT_WIDTH] + cr_q;
        // shifting by FRAC-1 folds in the factor of two of 2*zr*zi
        zi_next_s  = prod_ri_s[FRAC-1 +: BIT_WIDTH] + ci_q;
        last_x_s   = (x_q == X_W'(H_ACTIVE - 1));
        last_pix_s = last_x_s && (y_q == Y_W'(V_ACTIVE - 1));
    end

    assign unused_bits_s = ^{prod_ri_s, diff_s};

    // Next-state and next-output logic of the pixel sequencer
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cr_d       = cr_q;
        ci_d       = ci_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_INIT;
                    busy_d    = 1'b1;
                    x_d       = {X_W{1'b0}};
                    y_d       = {Y_W{1'b0}};
                    cr_d      = RE_MIN;
                    ci_d      = IM_MAX;
                    wr_addr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INIT: begin
                zr_d    = {BIT_WIDTH{1'b0}};
                zi_d    = {BIT_WIDTH{1'b0}};
                iter_d  = {ITER_W{1'b0}};
                state_d = ST_ITER;
            end

            ST_ITER: begin
                if (escaped_s || iter_max_s) begin
                    wr_data_d  = iter_q;
                    wr_valid_d = 1'b1;
                    state_d    = ST_WRITE;
                end else begin
                    zr_d   = zr_next_s;
                    zi_d   = zi_next_s;
                    iter_d = iter_q + ITER_W'(1);
                end
            end

            ST_WRITE: begin
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (last_x_s) begin
                        x_d  = {X_W{1'b0}};
                        cr_d = RE_MIN;
                        y_d  = y_q + Y_W'(1);
                        ci_d = ci_q - IM_STEP;
                    end else begin
                        x_d  = x_q + X_W'(1);
                        cr_d = cr_q + RE_STEP;
                    end
                    if (last_pix_s) begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_INIT;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= {X_W{1'b0}};
            y_q        <= {Y_W{1'b0}};
            cr_q       <= RE_MIN;
            ci_q       <= IM_MAX;
            zr_q       <= {BIT_WIDTH{1'b0}};
            zi_q       <= {BIT_WIDTH{1'b0}};
            iter_q     <= {ITER_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= {ITER_W{1'b0}};
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cr_q       <= cr_d;
            ci_q       <= ci_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Bench for mandelbrot_pixel_engine: a full default-geometry frame under random
// back-pressure, small parameter overrides from a vector table, and async reset
// in the middle of a frame. Pixel values come from an escape-time model below.
module tb_mandelbrot_pixel_engine;

    localparam int MAIN_MAX_ITER = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start_v;
    logic [3:0]  ready_v;
    logic        busy_a  [4];
    logic        done_a  [4];
    logic        valid_a [4];
    logic [11:0] addr_a  [4];
    logic [7:0]  data_a  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: default geometry and mapping, shortened iteration cap
    mandelbrot_pixel_engine #(.MAX_ITER(MAIN_MAX_ITER)) u_main (
        .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_a[0]), .done(done_a[0]),
        .wr_valid(valid_a[0]), .wr_ready(ready_v[0]), .wr_addr(addr_a[0]), .wr_data(data_a[0]));

    // Instance 1: 2x2 frame, every c at the origin
    mandelbrot_pixel_engine #(.H_ACTIVE(2), .V_ACTIVE(2), .RE_MIN(32'h0), .RE_STEP(32'h0),
        .IM_MAX(32'h0), .IM_STEP(32'h0)) u_zero (
        .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_a[1]), .done(done_a[1]),
        .wr_valid(valid_a[1]), .wr_ready(ready_v[1]), .wr_addr(addr_a[1]), .wr_data(data_a[1]));

    // Instance 2: single pixel, c = 1.0
    mandelbrot_pixel_engine #(.H_ACTIVE(1), .V_ACTIVE(1), .RE_MIN(32'h10000000), .RE_STEP(32'h0),
        .IM_MAX(32'h0), .IM_STEP(32'h0)) u_one (
        .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_a[2]), .done(done_a[2]),
        .wr_valid(valid_a[2]), .wr_ready(ready_v[2]), .wr_addr(addr_a[2]), .wr_data(data_a[2]));

    // Instance 3: single pixel, c = -2.0
    mandelbrot_pixel_engine #(.H_ACTIVE(1), .V_ACTIVE(1), .RE_MIN(32'hE0000000), .RE_STEP(32'h0),
        .IM_MAX(32'h0), .IM_STEP(32'h0)) u_m2 (
        .clk(clk), .reset(reset), .start(start_v[3]), .busy(busy_a[3]), .done(done_a[3]),
        .wr_valid(valid_a[3]), .wr_ready(ready_v[3]), .wr_addr(addr_a[3]), .wr_data(data_a[3]));

    typedef struct {
        int          k;
        int          h;
        int          v;
        logic [31:0] re_min;
        logic [31:0] im_max;
        int          exp_writes;
        int          exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Escape-time count of c = cr + i*ci in Q4.28, evaluated with plain integers
    function automatic int ref_iter(input logic [31:0] cr, input logic [31:0] ci, input int max_iter);
        longint      zr, zi, rr, ii, ri;
        logic [64:0] mag;
        logic [31:0] t_r, t_i;
        zr = 0;
        zi = 0;
        for (int n = 0; n <= max_iter; n++) begin
            rr  = zr * zr;
            ii  = zi * zi;
            ri  = zr * zi;
            mag = {1'b0, rr} + {1'b0, ii};
            if (mag > (65'd1 << 58)) return n;
            if (n == max_iter) return n;
            t_r = 32'((rr - ii) >>> 28) + cr;
            t_i = 32'(ri >>> 27) + ci;
            zr  = longint'($signed(t_r));
            zi  = longint'($signed(t_i));
        end
        return max_iter;
    endfunction

    // Start instance k, run its frame and check every write; optional first-write
    // stall, extra start pulse at write start_at, early exit after abort_at writes.
    task automatic run_frame(input int k, input int h, input int v, input int max_iter,
                             input logic [31:0] re_min, input logic [31:0] re_step,
                             input logic [31:0] im_max, input logic [31:0] im_step,
                             input int stall_first, input int start_at, input int abort_at,
                             input int fixed_data, output int nwrites);
        int          n, cyc, stalls, exp_d;
        logic        prev_v, prev_acc, acc, fin, pulsed;
        logic [11:0] prev_a;
        logic [7:0]  prev_d;
        logic [31:0] cr, ci;
        n = 0; cyc = 0; stalls = 0; fin = 1'b0; pulsed = 1'b0;
        prev_v = 1'b0; prev_acc = 1'b0; prev_a = 12'd0; prev_d = 8'd0;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        check("busy_after_start", {31'd0, busy_a[k]}, 32'd1);
        while (!fin && cyc < 80000) begin
            if (prev_v && !prev_acc) begin
                check("hold_valid", {31'd0, valid_a[k]}, 32'd1);
                check("hold_addr", {20'd0, addr_a[k]}, {20'd0, prev_a});
                check("hold_data", {24'd0, data_a[k]}, {24'd0, prev_d});
            end
            if (prev_acc) check("valid_drop", {31'd0, valid_a[k]}, 32'd0);
            if (valid_a[k] && n == 0 && stalls < stall_first) begin
                ready_v[k] = 1'b0;
                stalls++;
            end else begin
                ready_v[k] = ($urandom_range(0, 3) != 0);
            end
            if (start_at >= 0 && n == start_at && !pulsed) begin
                start_v[k] = 1'b1;
                pulsed = 1'b1;
            end else begin
                start_v[k] = 1'b0;
            end
            acc = valid_a[k] && ready_v[k];
            if (acc) begin
                cr = re_min + 32'(n % h) * re_step;
                ci = im_max - 32'(n / h) * im_step;
                exp_d = (fixed_data >= 0) ? fixed_data : ref_iter(cr, ci, max_iter);
                check("wr_addr", {20'd0, addr_a[k]}, 32'(n));
                check("wr_data", {24'd0, data_a[k]}, 32'(exp_d));
                n++;
            end
            prev_v = valid_a[k]; prev_acc = acc; prev_a = addr_a[k]; prev_d = data_a[k];
            @(negedge clk);
            cyc++;
            if (acc && n == h * v) begin
                start_v[k] = 1'b0;
                check("done_pulse", {31'd0, done_a[k]}, 32'd1);
                check("busy_at_done", {31'd0, busy_a[k]}, 32'd0);
                @(negedge clk);
                check("done_single", {31'd0, done_a[k]}, 32'd0);
                check("busy_idle", {31'd0, busy_a[k]}, 32'd0);
                fin = 1'b1;
            end
            if (abort_at >= 0 && n == abort_at) fin = 1'b1;
        end
        start_v[k] = 1'b0;
        ready_v[k] = 1'b0;
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL timeout inst %0d: %0d writes seen, expected %0d", k, n, h * v);
        end
        nwrites = n;
    endtask

    vec_t vecs [3];
    int   nw;

    initial begin
        vecs[0] = '{k: 1, h: 2, v: 2, re_min: 32'h00000000, im_max: 32'h0, exp_writes: 4, exp_data: 255};
        vecs[1] = '{k: 2, h: 1, v: 1, re_min: 32'h10000000, im_max: 32'h0, exp_writes: 1, exp_data: 3};
        vecs[2] = '{k: 3, h: 1, v: 1, re_min: 32'hE0000000, im_max: 32'h0, exp_writes: 1, exp_data: 255};

        reset   = 1'b1;
        start_v = 4'd0;
        ready_v = 4'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", {31'd0, busy_a[i]}, 32'd0);
            check("rst_done", {31'd0, done_a[i]}, 32'd0);
            check("rst_valid", {31'd0, valid_a[i]}, 32'd0);
            check("rst_addr", {20'd0, addr_a[i]}, 32'd0);
            check("rst_data", {24'd0, data_a[i]}, 32'd0);
        end
        reset = 1'b0;

        // Full default frame: 10-cycle stall on the first write, ignored start at write 50
        run_frame(0, 64, 48, MAIN_MAX_ITER, 32'hE0000000, 32'h00C00000, 32'h12000000,
                  32'h00C00000, 10, 50, -1, -1, nw);
        check("main_write_count", 32'(nw), 32'd3072);

        // Override corners from the vector table
        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i].k, vecs[i].h, vecs[i].v, 255, vecs[i].re_min, 32'h0,
                      vecs[i].im_max, 32'h0, 0, -1, -1, vecs[i].exp_data, nw);
            check("vec_write_count", 32'(nw), 32'(vecs[i].exp_writes));
        end

        // Async reset in the middle of a frame
        run_frame(0, 64, 48, MAIN_MAX_ITER, 32'hE0000000, 32'h00C00000, 32'h12000000,
                  32'h00C00000, 0, -1, 100, -1, nw);
        check("pre_reset_count", 32'(nw), 32'd100);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy_a[0]}, 32'd0);
        check("midrst_valid", {31'd0, valid_a[0]}, 32'd0);
        check("midrst_addr", {20'd0, addr_a[0]}, 32'd0);
        check("midrst_data", {24'd0, data_a[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(0, 64, 48, MAIN_MAX_ITER, 32'hE0000000, 32'h00C00000, 32'h12000000,
                  32'h00C00000, 0, -1, 6, -1, nw);
        check("restart_count", 32'(nw), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
